l2_way_array: RTL and testbench
===============================

# l2_way_array

Set-associative L2 data/metadata storage: `num_ways` independent ways of `num_sets` entries, each `width` bits. Supports byte-masked writes to a single way and a registered, all-ways-parallel read so the L2 controller can do hit selection one cycle after the lookup. A hardware clear sweep zeroes every entry after reset or on request, so no simulation-only initial blocks are needed. Sits under the L2 controller, beside the tag/valid/LRU arrays, and replaces single-way flat arrays.

## Interface
- `s_index`, default 3: index width.
- `num_sets`, default 2**s_index: entries per way.
- `num_ways`, default 2: way count, ≥1.
- `width`, default 32: bits per entry; multiple of 8.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `read` in 1: lookup request.
- `load` in 1: write request.
- `clear` in 1: start clear sweep (single-cycle pulse).
- `way` in $clog2(num_ways) (min 1): write way select.
- `index` in s_index: set for read and write.
- `byte_en` in width/8: per-byte write enable.
- `datain` in width: write data.
- `dataout` out num_ways*width: way w in bits [w*width +: width].
- `rvalid` out 1: dataout valid.
- `busy` out 1: clear sweep in progress.
- `parity_err` out num_ways: per-way read parity error, qualified by rvalid.

## Operation
- FSM states CLEAR, READY. Reset → CLEAR, sweep pointer 0.
- CLEAR: each cycle, all ways at the pointer set get zero data and matching parity, and the pointer increments. After writing set num_sets-1, go to READY. Takes exactly num_sets cycles. `busy`=1. `read`, `load` and `clear` are ignored. `rvalid` stays 0.
- READY: `clear`=1 → CLEAR with pointer 0 on the next edge. A `read`/`load` in that same cycle is still performed.
- Write: in READY with `load`=1, byte b of entry [way][index] takes datain byte b where byte_en[b]=1. Other bytes are unchanged. byte_en=0 is a legal no-op. `way` ≥ num_ways is a no-op.
- Read: in READY with `read`=1, all ways at `index` are captured into the output register.
- Same-cycle read and load to the same index is write-first. The written way returns the merged (post-write) entry; the other ways return stored data.
- Without `read`, `dataout` holds its last value and `rvalid`=0.
- Out-of-range index (num_sets < 2**s_index) is a no-op for writes. Reads return zero.

## Timing
- Reset values: dataout=0, rvalid=0, busy=1, parity_err=0.
- Read latency is 1. A `read` sampled at edge N gives dataout, rvalid=1 and parity_err valid after edge N.
- A write is visible to a read issued in the same cycle (via forwarding) and in all later cycles.
- `busy` falls on the edge that writes the last set. READY accepts requests from the next cycle on.
- An asynchronous `rst_n` assertion at any time, including mid-sweep, immediately returns all outputs to reset values. The sweep then restarts from set 0 after `rst_n` deasserts.
- Throughput is one read plus one write per cycle.

## Configuration
- `L2_ARRAY_PARITY_EN` defined: each way stores one even-parity bit per byte, written with the data (the cleared value is zero). On a read, each way's parity is recomputed and compared. A mismatch on any byte sets that way's `parity_err` bit alongside rvalid.
- Not defined: no parity storage, and `parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- Package `l2_pkg`:
  - state enum `l2_arr_state_t` {CLEAR, READY};
  - function `l2_bytes(width)`;
  - function `l2_parity(byte)`.
- Sub-module `l2_way_bank`, one instance per way via generate. It contains the storage array, the byte-masked write, the optional parity bits and the combinational read plus parity check.
- The top level holds the FSM, the sweep pointer, the forwarding merge and the output registers.
- Storage is logic, not RAM inference (`ramstyle = "logic"`).

## Test plan
- Reset sweep (num_sets=8): deassert rst_n. Required: busy=1 for exactly 8 cycles. Then reading each of sets 0..7 gives dataout=0, rvalid=1 one cycle later, parity_err=0.
- Byte mask: load way1 idx5, datain=0xAABBCCDD, byte_en=4'b0101, then read idx5. Required: way1 slice=0x00BB00DD, way0 slice=0.
- Forwarding: way0 idx3 holds 0x11223344. In one cycle, load way0 idx3 with 0xFFFFFFFF, byte_en=4'b1000, and read idx3. Required next cycle: way0=0xFF223344.
- Clear mid-run: write non-zero data to all sets, pulse `clear`, and issue reads while busy. Required: rvalid=0 for 8 cycles, after which all reads return 0.
- Reset mid-sweep: assert rst_n low at sweep cycle 4. Required: outputs at reset values at once; after release, busy=1 for a full 8 cycles.
- Parity (with `L2_ARRAY_PARITY_EN`): force-flip one stored bit in way1 idx2, then read idx2. Required: parity_err=2'b10 with rvalid=1. Without the macro, parity_err=0.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and helpers for the L2 way array and its per-way banks.
// Parity storage is controlled by the L2_ARRAY_PARITY_EN macro in the bank.
package l2_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } l2_arr_state_t;

  function automatic int l2_bytes(input int w);
    return w / 8;
  endfunction

  // Even parity: the stored bit makes the byte plus parity have an even count of ones.
  function automatic logic l2_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/l2_way_bank.sv
// One way of the L2 array: byte-masked write port and combinational read.
// With L2_ARRAY_PARITY_EN defined, one even-parity bit per byte is stored and checked.
module l2_way_bank
  import l2_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_sets = 2 ** s_index,
  parameter int width    = 32,
  localparam int NB      = l2_bytes(width)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [s_index-1:0] waddr,
  input  logic [NB-1:0]      be,
  input  logic [width-1:0]   wdata,
  input  logic [s_index-1:0] raddr,
  output logic [width-1:0]   rdata,
  output logic [NB-1:0]      rperr
);

  localparam logic [s_index:0] SET_LIM = (s_index + 1)'(num_sets);

  (* ramstyle = "logic" *) logic [width-1:0] mem_q [num_sets];

  logic rd_ok;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Sets beyond num_sets do not exist and read back as zero.
  assign rd_ok = ({1'b0, raddr} < SET_LIM);
  assign rdata = rd_ok ? mem_q[raddr] : '0;

`ifdef L2_ARRAY_PARITY_EN
  (* ramstyle = "logic" *) logic [NB-1:0] par_q [num_sets];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) par_q[waddr][b] <= l2_parity(wdata[b*8 +: 8]);
      end
    end
  end

  always_comb begin
    rperr = '0;
    if (rd_ok) begin
      for (int b = 0; b < NB; b++) begin
        rperr[b] = l2_parity(rdata[b*8 +: 8]) ^ par_q[raddr][b];
      end
    end
  end
`else
  assign rperr = '0;
`endif

endmodule

// File: rtl/l2_way_array.sv
// Set-associative L2 way array: clear sweep FSM, byte-masked single-way write,
// all-ways registered read with write-first forwarding. Parity via L2_ARRAY_PARITY_EN.
module l2_way_array
  import l2_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_sets = 2 ** s_index,
  parameter int num_ways = 2,
  parameter int width    = 32,
  localparam int WAY_W   = (num_ways > 1) ? $clog2(num_ways) : 1,
  localparam int NB      = l2_bytes(width)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      read,
  input  logic                      load,
  input  logic                      clear,
  input  logic [WAY_W-1:0]          way,
  input  logic [s_index-1:0]        index,
  input  logic [NB-1:0]             byte_en,
  input  logic [width-1:0]          datain,
  output logic [num_ways*width-1:0] dataout,
  output logic                      rvalid,
  output logic                      busy,
  output logic [num_ways-1:0]       parity_err
);

  localparam logic [s_index-1:0] LAST    = s_index'(num_sets - 1);
  localparam logic [s_index:0]   SET_LIM = (s_index + 1)'(num_sets);
  localparam logic [WAY_W:0]     WAY_LIM = (WAY_W + 1)'(num_ways);

  l2_arr_state_t               state_q;
  logic [s_index-1:0]          ptr_q;
  logic [num_ways*width-1:0]   dataout_q, dataout_d;
  logic                        rvalid_q;
  logic [num_ways-1:0]         perr_q, perr_d;

  logic                        sweeping, idx_ok, way_ok, wr_ok;
  logic [s_index-1:0]          bank_waddr;
  logic [NB-1:0]               bank_be;
  logic [width-1:0]            bank_wdata;

  assign sweeping = (state_q == CLEAR);
  assign idx_ok   = ({1'b0, index} < SET_LIM);
  assign way_ok   = ({1'b0, way} < WAY_LIM);
  assign wr_ok    = !sweeping && load && idx_ok && way_ok;

  // While sweeping, every way writes zero to the pointer set; otherwise the request.
  assign bank_waddr = sweeping ? ptr_q : index;
  assign bank_be    = sweeping ? '1    : byte_en;
  assign bank_wdata = sweeping ? '0    : datain;

  generate
    for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
      logic             we, fwd;
      logic [width-1:0] rdata;
      logic [NB-1:0]    rperr, fwd_be;

      assign fwd    = wr_ok && (way == WAY_W'(gi));
      assign we     = sweeping || fwd;
      assign fwd_be = fwd ? byte_en : '0;

      l2_way_bank #(
        .s_index (s_index),
        .num_sets(num_sets),
        .width   (width)
      ) u_bank (
        .clk  (clk),
        .we   (we),
        .waddr(bank_waddr),
        .be   (bank_be),
        .wdata(bank_wdata),
        .raddr(index),
        .rdata(rdata),
        .rperr(rperr)
      );

      // Freshly written bytes bypass the array and cannot carry a stored parity fault.
      for (genvar bi = 0; bi < NB; bi++) begin : g_byte
        assign dataout_d[gi*width + bi*8 +: 8] = fwd_be[bi] ? datain[bi*8 +: 8] : rdata[bi*8 +: 8];
      end
      assign perr_d[gi] = |(rperr & ~fwd_be);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      dataout_q <= '0;
      rvalid_q  <= 1'b0;
      perr_q    <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          rvalid_q <= 1'b0;
          perr_q   <= '0;
          if (ptr_q == LAST) begin
            state_q <= READY;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        READY: begin
          rvalid_q <= read;
          if (read) begin
            dataout_q <= dataout_d;
            perr_q    <= perr_d;
          end else begin
            perr_q <= '0;
          end
          if (clear) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign dataout    = dataout_q;
  assign rvalid     = rvalid_q;
  assign busy       = sweeping;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_l2_way_array.sv
// Randomized bench for l2_way_array against an array-level model of the way storage.
// Under L2_ARRAY_PARITY_EN a stored bit is flipped to exercise the parity check.
module tb_l2_way_array;

  localparam int SI = 3;
  localparam int NS = 8;
  localparam int NW = 2;
  localparam int W  = 32;
  localparam int NB = 4;
  localparam int WW = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read = 1'b0, load = 1'b0, clear = 1'b0;
  logic [WW-1:0]     way = '0;
  logic [SI-1:0]     index = '0;
  logic [NB-1:0]     byte_en = '0;
  logic [W-1:0]      datain = '0;
  logic [NW*W-1:0]   dataout;
  logic              rvalid, busy;
  logic [NW-1:0]     parity_err;

  always #5 clk = ~clk;

  l2_way_array #(
    .s_index (SI),
    .num_sets(NS),
    .num_ways(NW),
    .width   (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read      (read),
    .load      (load),
    .clear     (clear),
    .way       (way),
    .index     (index),
    .byte_en   (byte_en),
    .datain    (datain),
    .dataout   (dataout),
    .rvalid    (rvalid),
    .busy      (busy),
    .parity_err(parity_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: contents of every way/set, plus cycles left before requests are accepted.
  logic [W-1:0]    mdl [NW][NS];
  int              busy_cnt;
  logic [NW*W-1:0] exp_dout;
  logic            exp_rvalid, exp_busy;
  bit              check_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("busy", busy, exp_busy);
      chk("rvalid", rvalid, exp_rvalid);
      chk("dataout", dataout, exp_dout);
      chk("parity_err", parity_err, '0);
    end
  end

  task automatic model_reset();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) mdl[w][s] = '0;
    busy_cnt   = NS;
    exp_dout   = '0;
    exp_rvalid = 1'b0;
    exp_busy   = 1'b1;
  endtask

  // One clock of stimulus; returns at posedge+2 so the compare process has already run.
  task automatic step(input bit r, input bit l, input bit c, input int wy, input int idx,
                      input logic [NB-1:0] be, input logic [W-1:0] d);
    @(negedge clk);
    read = r; load = l; clear = c;
    way = WW'(wy); index = SI'(idx); byte_en = be; datain = d;
    if (busy_cnt > 0) begin
      busy_cnt--;
      exp_rvalid = 1'b0;
    end else begin
      if (l && wy < NW && idx < NS)
        for (int b = 0; b < NB; b++)
          if (be[b]) mdl[wy][idx][8*b +: 8] = d[8*b +: 8];
      exp_rvalid = r;
      if (r)
        for (int w = 0; w < NW; w++) exp_dout[w*W +: W] = (idx < NS) ? mdl[w][idx] : '0;
      if (c) begin
        for (int w = 0; w < NW; w++)
          for (int s = 0; s < NS; s++) mdl[w][s] = '0;
        busy_cnt = NS;
      end
    end
    exp_busy = (busy_cnt > 0);
    @(posedge clk);
    #2;
    if (r || l || c)
      $display("txn t=%0t rd=%0b ld=%0b clr=%0b way=%0d idx=%0d be=%b din=%h -> busy=%0b rvalid=%0b dout=%h",
               $time, r, l, c, wy, idx, be, d, busy, rvalid, dataout);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, '0, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", busy, 1'b1);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_dataout", dataout, '0);
    chk("reset_parity", parity_err, '0);

    // Power-up sweep: requests during it are ignored.
    rst_n = 1'b1;
    model_reset();
    check_en = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1, i, 4'hF, 32'hDEADBEEF);
    chk("sweep_busy_c7", busy, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1, 7, 4'hF, 32'hDEADBEEF);
    chk("sweep_busy_c8", busy, 1'b0);
    for (int i = 0; i < NS; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, i, '0, '0);
      chk("sweep_read_zero", dataout, '0);
      chk("sweep_read_rvalid", rvalid, 1'b1);
    end

    // Byte mask.
    step(1'b0, 1'b1, 1'b0, 1, 5, 4'b0101, 32'hAABBCCDD);
    step(1'b1, 1'b0, 1'b0, 0, 5, '0, '0);
    chk("byte_mask", dataout, 64'h00BB00DD_00000000);

    // Write-first forwarding.
    step(1'b0, 1'b1, 1'b0, 0, 3, 4'hF, 32'h11223344);
    step(1'b1, 1'b1, 1'b0, 0, 3, 4'b1000, 32'hFFFFFFFF);
    chk("forward_way0", dataout[31:0], 32'hFF223344);
    chk("forward_way1", dataout[63:32], 32'h0);

`ifdef L2_ARRAY_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1, 2, 4'hF, 32'h12345678);
    check_en = 1'b0;
    dut.g_way[1].u_bank.mem_q[2][0] = ~dut.g_way[1].u_bank.mem_q[2][0];
    step(1'b1, 1'b0, 1'b0, 0, 2, '0, '0);
    chk("parity_flip_err", parity_err, 2'b10);
    chk("parity_flip_rvalid", rvalid, 1'b1);
    dut.g_way[1].u_bank.mem_q[2][0] = ~dut.g_way[1].u_bank.mem_q[2][0];
    step(1'b1, 1'b0, 1'b0, 0, 2, '0, '0);
    check_en = 1'b1;
`else
    step(1'b0, 1'b1, 1'b0, 1, 2, 4'hF, 32'h12345678);
    step(1'b1, 1'b0, 1'b0, 0, 2, '0, '0);
    chk("parity_off", parity_err, '0);
    chk("parity_off_rvalid", rvalid, 1'b1);
`endif

    // Random traffic with occasional clear pulses.
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
           $urandom_range(0, NW - 1), $urandom_range(0, NS - 1),
           NB'($urandom), $urandom);
    end
    while (busy_cnt > 0) idle();

    // Clear mid-run: fill everything, then reads during the sweep must be ignored.
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) step(1'b0, 1'b1, 1'b0, w, s, 4'hF, $urandom | 32'h1);
    step(1'b1, 1'b0, 1'b0, 0, 6, '0, '0);
    chk("fill_nonzero", (dataout != '0), 1'b1);
    step(1'b0, 1'b0, 1'b1, 0, 0, '0, '0);
    for (int i = 0; i < NS; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, i, '0, '0);
      chk("clear_rvalid_low", rvalid, 1'b0);
    end
    for (int i = 0; i < NS; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, i, '0, '0);
      chk("clear_read_zero", dataout, '0);
    end

    // Reset mid-sweep.
    step(1'b0, 1'b1, 1'b0, 0, 4, 4'hF, 32'hCAFEF00D);
    step(1'b1, 1'b0, 1'b0, 0, 4, '0, '0);
    step(1'b0, 1'b0, 1'b1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) idle();
    check_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_dataout", dataout, '0);
    chk("midrst_parity", parity_err, '0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    check_en = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 0, i, '0, '0);
    chk("midrst_busy_c7", busy, 1'b1);
    idle();
    chk("midrst_busy_c8", busy, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 4, '0, '0);
    chk("midrst_read_zero", dataout, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
